// File: rtl/llm_chi_rsp_tx.sv
// CHI response transmit stage: Pld FIFO, credit flow control,
// rolling txnid tagging and a STOP/RUN link state machine.
module llm_chi_rsp_tx #(
  parameter  int DEPTH   = 4,
  parameter  int MAX_CRD = 4,
  parameter  int TXNID_W = 8,
  localparam int FLIT_W  = TXNID_W + 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pld_in_valid,
  input  logic [31:0]       pld_in_data,
  output logic              pld_in_ready,
  input  logic              link_up,
  input  logic              rsp_lcrdv,
  output logic              rsp_flitv,
  output logic [FLIT_W-1:0] rsp_flit,
  output logic [3:0]        crd_cnt,
  output logic [4:0]        fifo_cnt,
  output logic              crd_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_STOP,
    ST_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         mem_q [DEPTH];
  logic [31:0]         mem_d [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [3:0]          crd_q, crd_d;
  logic                crd_err_q, crd_err_d;
  logic [TXNID_W-1:0]  txnid_q, txnid_d;
  logic                flitv_q, flitv_d;
  logic [FLIT_W-1:0]   flit_q, flit_d;

  logic        push;
  logic        send;
  logic        link_drop;
  logic [31:0] head;

  assign pld_in_ready = (cnt_q < 5'(DEPTH));
  assign rsp_flitv    = flitv_q;
  assign rsp_flit     = flit_q;
  assign crd_cnt      = crd_q;
  assign fifo_cnt     = cnt_q;
  assign crd_err      = crd_err_q;

  always_comb begin
    push      = pld_in_valid && pld_in_ready;
    link_drop = (state_q == ST_RUN) && !link_up;
    // link_up is also qualified so a falling edge launches nothing
    send      = (state_q == ST_RUN) && link_up &&
                (cnt_q != 5'd0) && (crd_q != 4'd0);
    head      = mem_q[rd_ptr_q];

    state_d = link_up ? ST_RUN : ST_STOP;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = pld_in_data;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = send ? rd_ptr_q + AW'(1) : rd_ptr_q;

    cnt_d = cnt_q;
    unique case (1'b1)
      push && !send: cnt_d = cnt_q + 5'd1;
      !push && send: cnt_d = cnt_q - 5'd1;
      default:       cnt_d = cnt_q;
    endcase

    crd_d     = crd_q;
    crd_err_d = crd_err_q;
    unique case (1'b1)
      link_drop: crd_d = 4'd0;
      rsp_lcrdv && !send: begin
        if (crd_q == 4'(MAX_CRD)) crd_err_d = 1'b1;
        else                      crd_d = crd_q + 4'd1;
      end
      !rsp_lcrdv && send: crd_d = crd_q - 4'd1;
      default: crd_d = crd_q;
    endcase

    txnid_d = send ? txnid_q + TXNID_W'(1) : txnid_q;
    flitv_d = send;
    flit_d  = send ? {txnid_q, (head[23:16] != 8'h00), head} : flit_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STOP;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      crd_q     <= '0;
      crd_err_q <= 1'b0;
      txnid_q   <= '0;
      flitv_q   <= 1'b0;
      flit_q    <= '0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      crd_q     <= crd_d;
      crd_err_q <= crd_err_d;
      txnid_q   <= txnid_d;
      flitv_q   <= flitv_d;
      flit_q    <= flit_d;
    end
  end

endmodule

// File: tb/tb_llm_chi_rsp_tx.sv
// Scoreboard bench for llm_chi_rsp_tx: expected flits queued at push,
// checked in order as the DUT launches them.
module tb_llm_chi_rsp_tx;

  localparam int FW = 41;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pld_in_valid = 1'b0;
  logic [31:0]   pld_in_data = '0;
  logic          pld_in_ready;
  logic          link_up = 1'b0;
  logic          rsp_lcrdv = 1'b0;
  logic          rsp_flitv;
  logic [FW-1:0] rsp_flit;
  logic [3:0]    crd_cnt;
  logic [4:0]    fifo_cnt;
  logic          crd_err;

  int vectors = 0;
  int miscompares = 0;
  int nflits = 0;
  logic [FW-1:0] exp_q[$];
  logic [7:0]    exp_txn = '0;
  logic [FW-1:0] last_flit = '0;
  logic [3:0]    prev_crd = '0;

  llm_chi_rsp_tx dut (
    .clk(clk), .rst_n(rst_n),
    .pld_in_valid(pld_in_valid), .pld_in_data(pld_in_data),
    .pld_in_ready(pld_in_ready), .link_up(link_up),
    .rsp_lcrdv(rsp_lcrdv), .rsp_flitv(rsp_flitv),
    .rsp_flit(rsp_flit), .crd_cnt(crd_cnt),
    .fifo_cnt(fifo_cnt), .crd_err(crd_err)
  );

  always #5 clk = ~clk;

  // flit monitor / scoreboard checker
  always @(negedge clk) begin
    if (rst_n && rsp_flitv) begin
      logic [FW-1:0] e;
      nflits++;
      last_flit = rsp_flit;
      vectors++;
      if (prev_crd == 4'd0) begin
        miscompares++;
        $display("FAIL flit_no_credit: flit sent with crd_cnt=%0d", prev_crd);
      end
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL flit_unexpected: got %h, expected none", rsp_flit);
      end else begin
        e = exp_q.pop_front();
        if (rsp_flit !== e) begin
          miscompares++;
          $display("FAIL flit_data: got %h expected %h", rsp_flit, e);
        end
      end
    end
    prev_crd = crd_cnt;
  end

  function automatic logic [FW-1:0] mk_flit(input logic [7:0] t,
                                            input logic [31:0] w);
    return {t, (w[23:16] != 8'h00), w};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pld_in_valid = 1'b0;
    rsp_lcrdv = 1'b0;
    link_up = 1'b0;
    exp_q.delete();
    exp_txn = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] w);
    int t = 0;
    pld_in_valid = 1'b1;
    pld_in_data = w;
    while (!pld_in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t >= 200) begin
      miscompares++;
      $display("FAIL push_timeout: ready=%b expected 1", pld_in_ready);
    end else begin
      exp_q.push_back(mk_flit(exp_txn, w));
      exp_txn++;
    end
    @(negedge clk);
    pld_in_valid = 1'b0;
  endtask

  task automatic credit();
    rsp_lcrdv = 1'b1;
    @(negedge clk);
    rsp_lcrdv = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d flits pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({pld_in_ready, rsp_flitv, rsp_flit, crd_cnt, fifo_cnt, crd_err} !==
        {1'b1, 1'b0, 41'd0, 4'd0, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: rdy=%b v=%b flit=%h crd=%0d cnt=%0d err=%b",
               pld_in_ready, rsp_flitv, rsp_flit, crd_cnt, fifo_cnt, crd_err);
    end
  endtask

  task automatic test_basic();
    do_reset();
    link_up = 1'b1;
    @(negedge clk);
    credit();
    credit();
    vectors++;
    if (crd_cnt !== 4'd2) begin
      miscompares++;
      $display("FAIL basic_crd2: got %0d expected 2", crd_cnt);
    end
    push_word(32'h11000101);
    drain("basic");
    @(negedge clk);
    vectors++;
    if (crd_cnt !== 4'd1 || fifo_cnt !== 5'd0) begin
      miscompares++;
      $display("FAIL basic_after: crd=%0d cnt=%0d expected 1 0", crd_cnt, fifo_cnt);
    end
    vectors++;
    if (last_flit !== {8'h00, 1'b0, 32'h11000101}) begin
      miscompares++;
      $display("FAIL basic_flit: got %h expected %h", last_flit,
               {8'h00, 1'b0, 32'h11000101});
    end
  endtask

  task automatic test_starve();
    do_reset();
    link_up = 1'b1;
    for (int i = 0; i < 3; i++) push_word(32'h2200_0000 | i);
    repeat (3) @(negedge clk);
    vectors++;
    if (fifo_cnt !== 5'd3 || exp_q.size() != 3) begin
      miscompares++;
      $display("FAIL starve_hold: cnt=%0d pend=%0d expected 3 3", fifo_cnt, exp_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      credit();
      repeat (4) @(negedge clk);
      vectors++;
      if (exp_q.size() != 2 - i) begin
        miscompares++;
        $display("FAIL starve_step%0d: pend=%0d expected %0d", i, exp_q.size(), 2 - i);
      end
    end
    vectors++;
    if (last_flit[40:33] !== 8'd2 || fifo_cnt !== 5'd0) begin
      miscompares++;
      $display("FAIL starve_end: txnid=%0d cnt=%0d expected 2 0", last_flit[40:33], fifo_cnt);
    end
  endtask

  task automatic test_full();
    int first = -1, last = -1, n = 0;
    logic acc = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) push_word(32'h3300_0000 | i);
    pld_in_valid = 1'b1;
    pld_in_data = 32'h3300_0004;
    repeat (3) @(negedge clk);
    vectors++;
    if (pld_in_ready !== 1'b0 || fifo_cnt !== 5'd4) begin
      miscompares++;
      $display("FAIL full_state: rdy=%b cnt=%0d expected 0 4", pld_in_ready, fifo_cnt);
    end
    for (int i = 0; i < 4; i++) credit();
    link_up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pld_in_valid) begin
        if (acc) pld_in_valid = 1'b0;
        else if (pld_in_ready) begin
          exp_q.push_back(mk_flit(exp_txn, pld_in_data));
          exp_txn++;
          acc = 1'b1;
        end
      end
      if (rsp_flitv) begin
        n++;
        if (first < 0) first = i;
        last = i;
      end
    end
    pld_in_valid = 1'b0;
    vectors++;
    if (n != 4 || last - first != 3) begin
      miscompares++;
      $display("FAIL full_burst: flits=%0d span=%0d expected 4 3", n, last - first);
    end
    vectors++;
    if (!acc || fifo_cnt !== 5'd1) begin
      miscompares++;
      $display("FAIL full_fifth: acc=%b cnt=%0d expected 1 1", acc, fifo_cnt);
    end
    credit();
    drain("full");
  endtask

  task automatic test_err_wrap();
    do_reset();
    link_up = 1'b1;
    push_word(32'hFF010000);
    credit();
    drain("err");
    vectors++;
    if (last_flit[32] !== 1'b1) begin
      miscompares++;
      $display("FAIL err_bit: got %b expected 1", last_flit[32]);
    end
    for (int i = 1; i < 257; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (i[1:0] == 2'b00) w[23:16] = 8'h00;
      push_word(w);
      credit();
    end
    drain("wrap");
    vectors++;
    if (last_flit[40:33] !== 8'h00 || nflits == 0) begin
      miscompares++;
      $display("FAIL wrap_txnid: got %h expected 00", last_flit[40:33]);
    end
  endtask

  task automatic test_credit();
    do_reset();
    link_up = 1'b1;
    for (int i = 0; i < 4; i++) credit();
    vectors++;
    if (crd_cnt !== 4'd4 || crd_err !== 1'b0) begin
      miscompares++;
      $display("FAIL crd_four: crd=%0d err=%b expected 4 0", crd_cnt, crd_err);
    end
    credit();
    vectors++;
    if (crd_cnt !== 4'd4 || crd_err !== 1'b1) begin
      miscompares++;
      $display("FAIL crd_overflow: crd=%0d err=%b expected 4 1", crd_cnt, crd_err);
    end
    push_word(32'h4400_0001);
    credit();
    vectors++;
    if (crd_cnt !== 4'd4 || rsp_flitv !== 1'b1) begin
      miscompares++;
      $display("FAIL crd_simul: crd=%0d v=%b expected 4 1", crd_cnt, rsp_flitv);
    end
    drain("crd");
  endtask

  task automatic test_link_drop();
    int base;
    do_reset();
    push_word(32'h5500_0000);
    push_word(32'h5500_0001);
    for (int i = 0; i < 3; i++) credit();
    link_up = 1'b1;
    @(negedge clk);
    link_up = 1'b0;
    base = nflits;
    @(negedge clk);
    vectors++;
    if (crd_cnt !== 4'd0 || rsp_flitv !== 1'b0 || fifo_cnt !== 5'd2) begin
      miscompares++;
      $display("FAIL drop_state: crd=%0d v=%b cnt=%0d expected 0 0 2",
               crd_cnt, rsp_flitv, fifo_cnt);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (nflits != base || fifo_cnt !== 5'd2) begin
      miscompares++;
      $display("FAIL drop_hold: flits=%0d cnt=%0d expected %0d 2",
               nflits - base, fifo_cnt, 0);
    end
    push_word(32'h5500_0002);
    push_word(32'h5500_0003);
    for (int i = 0; i < 5; i++) credit();
    link_up = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({pld_in_ready, rsp_flitv, rsp_flit, crd_cnt, fifo_cnt, crd_err} !==
        {1'b1, 1'b0, 41'd0, 4'd0, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset: rdy=%b v=%b flit=%h crd=%0d cnt=%0d err=%b",
               pld_in_ready, rsp_flitv, rsp_flit, crd_cnt, fifo_cnt, crd_err);
    end
    exp_q.delete();
    exp_txn = '0;
    link_up = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_starve();
    test_full();
    test_err_wrap();
    test_credit();
    test_link_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
